// File: rtl/slide_intf.sv
// Slide-pot scanner: round-robins six A2D channels and
// keeps the latest 12-bit reading of each pot in its own register.
module slide_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME
);

  typedef enum logic [1:0] {
    START,
    WAIT,
    STORE
  } state_t;

  state_t     state;
  logic [2:0] slot;
  logic [2:0] slot_nxt;
  logic       capture;

  // Slot order LP, B1, B2, B3, HP, VOLUME on A2D channels 1,0,4,2,3,7
  function automatic logic [2:0] chan_of(input logic [2:0] s);
    logic [2:0] c;
    case (s)
      3'd0:    c = 3'd1;
      3'd1:    c = 3'd0;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      3'd5:    c = 3'd7;
      default: c = 3'd1;
    endcase
    return c;
  endfunction

  // Next slot index, wrapping after VOLUME
  always_comb begin
    slot_nxt = 3'd0;
    if (slot != 3'd5)
      slot_nxt = slot + 3'd1;
  end

  assign capture = (state == WAIT) && cnv_cmplt;

  // Scan FSM; strt_cnv is high exactly while in START.
  // Out of reset START has strt_cnv low, so it first raises the
  // pulse for one cycle before moving on to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= START;
      slot     <= 3'd0;
      strt_cnv <= 1'b0;
      chnnl    <= 3'd1;
    end else begin
      case (state)
        START: begin
          if (strt_cnv) begin
            strt_cnv <= 1'b0;
            state    <= WAIT;
          end else begin
            strt_cnv <= 1'b1;
          end
        end
        WAIT: begin
          if (cnv_cmplt)
            state <= STORE;
        end
        STORE: begin
          slot     <= slot_nxt;
          chnnl    <= chan_of(slot_nxt);
          strt_cnv <= 1'b1;
          state    <= START;
        end
        default: begin
          state    <= START;
          strt_cnv <= 1'b0;
        end
      endcase
    end
  end

  // Capture the conversion result into the current slot's register
  always_ff @(posedge clk) begin
    if (rst) begin
      POT_LP <= 12'h000;
      POT_B1 <= 12'h000;
      POT_B2 <= 12'h000;
      POT_B3 <= 12'h000;
      POT_HP <= 12'h000;
      VOLUME <= 12'h000;
    end else if (capture) begin
      case (slot)
        3'd0:    POT_LP <= res;
        3'd1:    POT_B1 <= res;
        3'd2:    POT_B2 <= res;
        3'd3:    POT_B3 <= res;
        3'd4:    POT_HP <= res;
        3'd5:    VOLUME <= res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slide_intf.sv
// Bench for slide_intf: acts as the A2D converter and checks
// channel order, latency, captures, stalls and reset behaviour.
module tb_slide_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] POT_LP, POT_B1, POT_B2;
  logic [11:0] POT_B3, POT_HP, VOLUME;

  int tests = 0;
  int fails = 0;

  // Reference: six pot values by scan slot, plus current slot
  logic [11:0] pot [6];
  int          slot;
  logic [2:0]  order [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  typedef struct {
    logic [11:0] r;
    int          dly;
    bit          spur;
    logic [2:0]  chan;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  slide_intf dut (
    .clk       (clk),
    .rst       (rst),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .POT_LP    (POT_LP),
    .POT_B1    (POT_B1),
    .POT_B2    (POT_B2),
    .POT_B3    (POT_B3),
    .POT_HP    (POT_HP),
    .VOLUME    (VOLUME)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm);
    logic [71:0] act, exp;
    act = {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME};
    exp = {pot[0], pot[1], pot[2], pot[3], pot[4], pot[5]};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) pot[i] = 12'h000;
    slot = 0;
  endtask

  // Wait (bounded) for a strt_cnv pulse, then check its channel
  task automatic wait_start();
    int n = 0;
    while (strt_cnv !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {31'd0, strt_cnv}, 32'd1);
    chk("chnnl", {29'd0, chnnl}, {29'd0, order[slot]});
  endtask

  // Entry/exit: at the negedge of a strt_cnv cycle
  task automatic convert(input logic [11:0] r, input int dly,
                         input bit spur);
    if (spur) begin
      cnv_cmplt = 1'b1;
      res       = ~r;
    end
    @(negedge clk);
    cnv_cmplt = 1'b0;
    chk("pulse_width", {31'd0, strt_cnv}, 32'd0);
    repeat (dly - 1) @(negedge clk);
    cnv_cmplt = 1'b1;
    res       = r;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res       = $urandom;
    pot[slot] = r;
    slot      = (slot + 1) % 6;
    chk_outs("capture");
    chk("strt_store", {31'd0, strt_cnv}, 32'd0);
    @(negedge clk);
    chk("latency", {31'd0, strt_cnv}, 32'd1);
    wait_start();
  endtask

  initial begin
    logic [2:0]  c0;
    logic [71:0] snap;
    int          bad;

    vecs[0] = '{12'h111, 5, 1'b0, 3'd1};
    vecs[1] = '{12'h222, 5, 1'b0, 3'd0};
    vecs[2] = '{12'h333, 5, 1'b1, 3'd4};
    vecs[3] = '{12'h444, 5, 1'b0, 3'd2};
    vecs[4] = '{12'h555, 5, 1'b0, 3'd3};
    vecs[5] = '{12'h666, 5, 1'b0, 3'd7};
    vecs[6] = '{12'hABC, 5, 1'b0, 3'd1};

    rst       = 1'b1;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_outs("reset_outs");
    chk("reset_chnnl", {29'd0, chnnl}, 32'd1);
    chk("reset_strt", {31'd0, strt_cnv}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_strt", {31'd0, strt_cnv}, 32'd1);
    wait_start();

    // Full scan plus wrap-around
    for (int i = 0; i < 7; i++) begin
      chk("vec_chan", {29'd0, chnnl}, {29'd0, vecs[i].chan});
      convert(vecs[i].r, vecs[i].dly, vecs[i].spur);
    end
    chk("wrap_lp", {20'd0, POT_LP}, 32'hABC);
    chk("wrap_vol", {20'd0, VOLUME}, 32'h666);

    // Stall for 100 cycles with no cnv_cmplt
    @(negedge clk);
    c0   = chnnl;
    snap = {POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME};
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (strt_cnv !== 1'b0 || chnnl !== c0) bad++;
      if ({POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME} !== snap)
        bad++;
    end
    chk("stall", bad, 0);
    cnv_cmplt = 1'b1;
    res       = 12'h5A5;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    pot[slot] = 12'h5A5;
    slot      = (slot + 1) % 6;
    chk_outs("stall_capture");
    @(negedge clk);
    chk("stall_latency", {31'd0, strt_cnv}, 32'd1);
    wait_start();

    // Randomized conversions, some with spurious early cnv_cmplt
    for (int i = 0; i < 40; i++)
      convert(12'($urandom), int'($urandom_range(1, 8)),
              ($urandom_range(0, 3) == 0));

    // Reset during WAIT on channel 4
    for (int i = 0; i < 6 && order[slot] != 3'd4; i++)
      convert(12'($urandom), 3, 1'b0);
    chk("at_ch4", {29'd0, chnnl}, 32'd4);
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    cnv_cmplt = 1'b1;
    res       = 12'hFFF;
    @(negedge clk);
    rst       = 1'b0;
    cnv_cmplt = 1'b0;
    model_reset();
    chk_outs("midreset_outs");
    chk("midreset_chnnl", {29'd0, chnnl}, 32'd1);
    chk("midreset_strt", {31'd0, strt_cnv}, 32'd0);
    @(negedge clk);
    chk("restart_strt", {31'd0, strt_cnv}, 32'd1);
    wait_start();
    convert(12'h123, 2, 1'b0);
    chk("restart_lp", {20'd0, POT_LP}, 32'h123);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
